seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Multiplexed scan driver for the two 4-digit seven-segment displays exported by processor_arm on D0_seg/D0_a and D1_seg/D1_a.
- Takes a 32-bit value written by the processor's I/O path:
  - D0 shows value[15:0].
  - D1 shows value[31:16].
- Refreshes one digit per display per scan slot.
- New values are double-buffered and committed only at frame boundaries, so no digit ever shows a mix of old and new values.

Parameters:
- DIV, 1000: i_mclk cycles per digit slot; legal range 2..65535.
- BLANK_CYC, 1: cycles at the start of each slot with all anodes off, for anti-ghosting; must be < DIV.

Ports:
- i_mclk  in  1  system clock; all state updates on its rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_value  in  32  hex value to display.
- i_dp  in  8  decimal point enables; bits [3:0] for D0 digits 0..3, bits [7:4] for D1.
- i_load  in  1  single-cycle strobe; captures i_value and i_dp into the pending register.
- o_pending  out  1  high while a loaded value is waiting for commit.
- o_frame  out  1  one-cycle pulse when a full 4-slot scan completes.
- D0_seg  out  8  active-low segments {dp,g,f,e,d,c,b,a} for display 0.
- D0_a  out  4  active-low anodes for display 0; bit n = digit n; digit 0 is least significant.
- D1_seg  out  8  same as D0_seg, for display 1.
- D1_a  out  4  same as D0_a, for display 1.

Behaviour:
- Reset (asynchronous, any time, including mid-slot):
  - prescaler=0, digit index=0.
  - committed value/dp=0, pending cleared, o_pending=0, o_frame=0.
  - D0_seg=D1_seg=8'hFF, D0_a=D1_a=4'hF.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick = (count==DIV-1).
  - On tick, digit index advances 0→1→2→3→0.
- Outputs:
  - All registered; they reflect the state of the previous edge.
  - During count<BLANK_CYC: anodes 4'hF, segs 8'hFF.
  - Otherwise: anode bit [index]=0, all other anode bits 1.
  - seg[6:0] = decode(nibble[index]); seg[7] = ~dp[index].
  - D1 uses the same index, driven from the upper half of the value.
- Decode, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - Listed codes include bit7=1 (dp off).
- Load:
  - i_load at an edge: pending<=i_value/i_dp, o_pending<=1.
  - A second load before commit overwrites pending; last write wins, no error.
- Commit:
  - Occurs on a tick with index==3.
  - If pending is valid: committed<=pending, o_pending<=0.
  - o_frame<=1 for exactly one cycle on that edge.
- Simultaneous i_load and commit edge: i_value/i_dp go directly into committed, and o_pending<=0.
- Commit latency: a load is visible on the displays from the first non-blank cycle of the next slot-0 period.
  - Worst case ≈ 4*DIV+BLANK_CYC+1 cycles after i_load.
- i_load while i_reset is high is ignored.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Per display, any digit n>0 is forced to segs[6:0]=7'h7F when its nibble and all higher nibbles of that display are zero.
  - Digit 0 is always shown.
  - dp is unaffected; a digit with dp set still lights its dp.
- Undefined: all digits always decoded; a zero value shows "0000".

Test Plan:
- All scenarios use DIV=4, BLANK_CYC=1.
- Reset mid-slot (i_reset pulsed 3 ns asynchronously) → outputs go immediately to segs=8'hFF, anodes=4'hF, o_pending=0; after release, first slot-0 non-blank cycle shows D0_seg=D1_seg=8'hC0, D0_a=D1_a=4'b1110.
- Load 32'h0123_4567 with i_dp=0 → o_pending=1 until the index-3 tick, o_frame pulses; the next frame shows:
  - D0: slot0=F8, slot1=82, slot2=92, slot3=99.
  - D1: slot0=B0, slot1=A4, slot2=F9, slot3=C0.
  - Anodes are 4'b1110/1101/1011/0111 in slots 0..3; each slot's first cycle is all-off.
- Two loads before commit, 32'h1111_1111 then 32'hFFFF_FFFF → only FFFF_FFFF is ever displayed (all slots 8'h8E); 1111_1111 never appears.
- i_load asserted exactly on the commit edge with 32'hAAAA_0000 → o_pending stays 0; the next frame shows D1=88 in every slot and D0=C0 (feature off).
- i_dp=8'h01, value 0 → D0 slot0 = 8'h40; other D0 slots C0; all D1 slots C0.
- SEG7_LEADING_ZERO_BLANK_EN defined, value 32'h0000_0050:
  - D0 slots 2,3 = 8'hFF; slot1 = 92; slot0 = C0.
  - D1 slots 1..3 = FF; slot0 = C0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Two-display, four-digit multiplexed seven-segment scan driver.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 1
) (
  input  logic        i_mclk,
  input  logic        i_reset,
  input  logic [31:0] i_value,
  input  logic [7:0]  i_dp,
  input  logic        i_load,
  output logic        o_pending,
  output logic        o_frame,
  output logic [7:0]  D0_seg,
  output logic [3:0]  D0_a,
  output logic [7:0]  D1_seg,
  output logic [3:0]  D1_a
);

  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [31:0] pend_val;
  logic [7:0]  pend_dp;
  logic [31:0] com_val;
  logic [7:0]  com_dp;
  logic        tick;
  logic        commit;
  logic        blank;

  assign tick   = (cnt == 16'(DIV - 1));
  assign commit = tick && (idx == 2'd3);
  assign blank  = (cnt < 16'(BLANK_CYC));

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] seg_of(
    input logic [15:0] h,
    input logic [3:0]  dp,
    input logic [1:0]  i
  );
    logic [7:0] s;
    s = {~dp[i], dec(h[{i, 2'b00} +: 4])};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // digit is blank when it and every higher digit are zero
    if (i != 2'd0 && (h >> {i, 2'b00}) == 16'd0)
      s[6:0] = 7'h7F;
`endif
    return s;
  endfunction

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      cnt       <= '0;
      idx       <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      com_val   <= '0;
      com_dp    <= '0;
      o_pending <= 1'b0;
      o_frame   <= 1'b0;
      D0_seg    <= 8'hFF;
      D1_seg    <= 8'hFF;
      D0_a      <= 4'hF;
      D1_a      <= 4'hF;
    end else begin
      cnt     <= tick ? 16'd0 : cnt + 16'd1;
      o_frame <= commit;
      if (tick)
        idx <= idx + 2'd1;

      if (commit) begin
        if (i_load) begin
          com_val <= i_value;
          com_dp  <= i_dp;
        end else if (o_pending) begin
          com_val <= pend_val;
          com_dp  <= pend_dp;
        end
        o_pending <= 1'b0;
      end else if (i_load) begin
        pend_val  <= i_value;
        pend_dp   <= i_dp;
        o_pending <= 1'b1;
      end

      if (blank) begin
        D0_seg <= 8'hFF;
        D1_seg <= 8'hFF;
        D0_a   <= 4'hF;
        D1_a   <= 4'hF;
      end else begin
        D0_seg <= seg_of(com_val[15:0], com_dp[3:0], idx);
        D1_seg <= seg_of(com_val[31:16], com_dp[7:4], idx);
        D0_a   <= ~(4'b0001 << idx);
        D1_a   <= ~(4'b0001 << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver.
// Reference model follows SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRM   = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] val = '0;
  logic [7:0]  dp  = '0;
  logic        ld  = 1'b0;
  logic        pending, frame;
  logic [7:0]  d0_seg, d1_seg;
  logic [3:0]  d0_a, d1_a;

  seg7_scan_driver #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .i_mclk(clk),
    .i_reset(rst),
    .i_value(val),
    .i_dp(dp),
    .i_load(ld),
    .o_pending(pending),
    .o_frame(frame),
    .D0_seg(d0_seg),
    .D0_a(d0_a),
    .D1_seg(d1_seg),
    .D1_a(d1_a)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0] lut [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // model: edges since reset, committed and pending contents
  int          s;
  logic [31:0] m_com, m_pv;
  logic [7:0]  m_cdp, m_pdp;
  bit          m_pend, m_frame;
  logic [7:0]  e0s, e1s;
  logic [3:0]  e0a, e1a;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s s=%0d got=%h exp=%h", tag, s, got, exp);
    end
  endtask

  function automatic logic [7:0] digit(input logic [15:0] h,
                                       input logic [3:0] d,
                                       input int n);
    logic [7:0] r;
    int upper;
    upper = int'(h) / (1 << (4 * n));
    r = lut[upper % 16];
    r[7] = ~d[n];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (n > 0 && upper == 0) r[6:0] = 7'h7F;
`endif
    return r;
  endfunction

  task automatic model_reset();
    s = 0; m_com = '0; m_cdp = '0; m_pv = '0; m_pdp = '0;
    m_pend = 0; m_frame = 0;
  endtask

  task automatic check_outs(input string t);
    chk({t, "_d0seg"}, 32'(d0_seg), 32'(e0s));
    chk({t, "_d1seg"}, 32'(d1_seg), 32'(e1s));
    chk({t, "_d0a"}, 32'(d0_a), 32'(e0a));
    chk({t, "_d1a"}, 32'(d1_a), 32'(e1a));
    chk({t, "_pend"}, 32'(pending), 32'(m_pend));
    chk({t, "_frame"}, 32'(frame), 32'(m_frame));
  endtask

  task automatic step();
    int slot_pos, slot;
    bit at_commit;
    @(posedge clk);
    slot_pos  = s % DIV;
    slot      = (s / DIV) % 4;
    at_commit = (s % FRM) == FRM - 1;
    if (slot_pos < BLANK) begin
      e0s = 8'hFF; e1s = 8'hFF; e0a = 4'hF; e1a = 4'hF;
    end else begin
      e0s = digit(m_com[15:0], m_cdp[3:0], slot);
      e1s = digit(m_com[31:16], m_cdp[7:4], slot);
      e0a = 4'hF & ~(4'(1) << slot);
      e1a = e0a;
    end
    m_frame = at_commit;
    if (at_commit) begin
      if (ld) begin m_com = val; m_cdp = dp; end
      else if (m_pend) begin m_com = m_pv; m_cdp = m_pdp; end
      m_pend = 0;
    end else if (ld) begin
      m_pv = val; m_pdp = dp; m_pend = 1;
    end
    s++;
    #1;
    check_outs("run");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] d);
    val = v; dp = d; ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    e0s = 8'hFF; e1s = 8'hFF; e0a = 4'hF; e1a = 4'hF;
    check_outs("rst");
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // load held during reset edges must be ignored
    val = 32'hDEAD_BEEF; dp = 8'hFF; ld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e0s = 8'hFF; e1s = 8'hFF; e0a = 4'hF; e1a = 4'hF;
    check_outs("init");
    ld = 1'b0;
    #2 rst = 1'b0;
    run(20);

    run(2);
    reset_pulse();
    run(20);

    load(32'h0123_4567, 8'h00);
    run(40);

    while (s % FRM != 2) step();
    load(32'h1111_1111, 8'h00);
    load(32'hFFFF_FFFF, 8'h00);
    run(40);

    while (s % FRM != FRM - 1) step();
    load(32'hAAAA_0000, 8'h00);
    run(36);

    load(32'h0000_0000, 8'h01);
    run(36);

    load(32'h0000_0050, 8'h00);
    run(36);

    load(32'h0000_0000, 8'h00);
    run(36);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) reset_pulse();
      if ($urandom_range(0, 7) == 0)
        load($urandom() & ($urandom_range(0, 1) ? 32'hFFFF_FFFF
                                                : 32'h000F_00FF),
             8'($urandom()));
      else
        step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
